// File: rtl/osc_pkg.sv
// Shared widths, LFSR constants and wave-select codes for the oscillator voice.
// The parabolic sine shaper lives here so other voices can reuse it.
package osc_pkg;

   localparam int PHASE_W  = 24;
   localparam int SAMPLE_W = 8;
   localparam int LFSR_W   = 16;

   localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [2:0] {
      WAVE_SQUARE   = 3'd0,
      WAVE_SAW      = 3'd1,
      WAVE_TRIANGLE = 3'd2,
      WAVE_SINE     = 3'd3,
      WAVE_NOISE    = 3'd4
   } wave_sel_e;

   // Takes phase[23:15]; x*(255-x) peaks at 16256, so h fits in 7 bits.
   function automatic logic [SAMPLE_W-1:0] sine_approx(input logic [8:0] ph_top);
      logic [15:0] x16;
      logic [15:0] prod;
      logic [7:0]  h;
      x16  = {8'd0, ph_top[7:0]};
      prod = x16 * (16'd255 - x16);
      h    = {1'b0, prod[13:7]};
      sine_approx = ph_top[8] ? (8'd128 - h) : (8'd128 + h);
   endfunction

endpackage

// File: rtl/delta_sigma_dac.sv
// First-order delta-sigma modulator: ones density on dac_o equals data_i/256.
module delta_sigma_dac
   import osc_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [SAMPLE_W-1:0] data_i,
   output logic                dac_o
);

   logic [SAMPLE_W-1:0] acc_q;
   logic                dac_q;
   logic [SAMPLE_W:0]   sum_d;

   // Only the low byte is kept; the carry is the output bit.
   assign sum_d = {1'b0, acc_q} + {1'b0, data_i};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc_q <= '0;
         dac_q <= 1'b0;
      end else begin
         acc_q <= sum_d[SAMPLE_W-1:0];
         dac_q <= sum_d[SAMPLE_W];
      end
   end

   assign dac_o = dac_q;

endmodule

// File: rtl/phase_accumulator.sv
// 24-bit phase accumulator; carry out of the top bit is discarded.
module phase_accumulator
   import osc_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               enable_i,
   input  logic [PHASE_W-1:0] frequency_i,
   output logic [PHASE_W-1:0] phase_o
);

   logic [PHASE_W-1:0] phase_q;
   logic [PHASE_W-1:0] phase_d;

   always_comb begin
      phase_d = phase_q;
      if (enable_i) phase_d = phase_q + frequency_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) phase_q <= '0;
      else       phase_q <= phase_d;
   end

   assign phase_o = phase_q;

endmodule

// File: rtl/waveform_generators.sv
// Parallel shapers fed by the top nine phase bits; square is combinational,
// saw/triangle/sine are registered one clock behind the phase, noise is an LFSR.
module waveform_generators
   import osc_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                enable_i,
   input  logic [8:0]          phase_top_i,
   input  logic [SAMPLE_W-1:0] duty_i,
   output logic [SAMPLE_W-1:0] square_o,
   output logic [SAMPLE_W-1:0] saw_o,
   output logic [SAMPLE_W-1:0] tri_o,
   output logic [SAMPLE_W-1:0] sine_o,
   output logic [SAMPLE_W-1:0] noise_o
);

   logic [SAMPLE_W-1:0] saw_q,  saw_d;
   logic [SAMPLE_W-1:0] tri_q,  tri_d;
   logic [SAMPLE_W-1:0] sine_q, sine_d;
   logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
   logic [7:0]          x;

   assign x = phase_top_i[7:0];

   always_comb begin
      saw_d  = phase_top_i[8:1];
      tri_d  = phase_top_i[8] ? ~x : x;
      sine_d = sine_approx(phase_top_i);
      lfsr_d = lfsr_q;
      if (enable_i)
         lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
   end

   // Shapers follow the phase every clock, so they freeze whenever the phase does.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         saw_q  <= '0;
         tri_q  <= '0;
         sine_q <= 8'd128;
         lfsr_q <= LFSR_SEED;
      end else begin
         saw_q  <= saw_d;
         tri_q  <= tri_d;
         sine_q <= sine_d;
         lfsr_q <= lfsr_d;
      end
   end

   assign square_o = (phase_top_i[8:1] < duty_i) ? 8'hFF : 8'h00;
   assign saw_o    = saw_q;
   assign tri_o    = tri_q;
   assign sine_o   = sine_q;
   assign noise_o  = lfsr_q[SAMPLE_W-1:0];

endmodule

// File: rtl/osc_wave_dac_core.sv
// Single oscillator voice: phase accumulator, waveform shapers, selector mux
// and a 1-bit PDM DAC on the selected sample.
module osc_wave_dac_core
   import osc_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [PHASE_W-1:0]  frequency,
   input  logic [SAMPLE_W-1:0] duty_cycle,
   input  logic [2:0]          wave_select,
   output logic [PHASE_W-1:0]  phase_out,
   output logic [SAMPLE_W-1:0] square_out,
   output logic [SAMPLE_W-1:0] sawtooth_out,
   output logic [SAMPLE_W-1:0] triangle_out,
   output logic [SAMPLE_W-1:0] sine_out,
   output logic [SAMPLE_W-1:0] noise_out,
   output logic [SAMPLE_W-1:0] selected_wave,
   output logic                dac_out
);

   phase_accumulator u_phase (
      .clk_i       (clk),
      .rst_i       (rst),
      .enable_i    (enable),
      .frequency_i (frequency),
      .phase_o     (phase_out)
   );

   waveform_generators u_wave (
      .clk_i       (clk),
      .rst_i       (rst),
      .enable_i    (enable),
      .phase_top_i (phase_out[PHASE_W-1:PHASE_W-9]),
      .duty_i      (duty_cycle),
      .square_o    (square_out),
      .saw_o       (sawtooth_out),
      .tri_o       (triangle_out),
      .sine_o      (sine_out),
      .noise_o     (noise_out)
   );

   // Unused select codes fall back to square.
   always_comb begin
      selected_wave = square_out;
      case (wave_sel_e'(wave_select))
         WAVE_SAW:      selected_wave = sawtooth_out;
         WAVE_TRIANGLE: selected_wave = triangle_out;
         WAVE_SINE:     selected_wave = sine_out;
         WAVE_NOISE:    selected_wave = noise_out;
         default:       selected_wave = square_out;
      endcase
   end

   delta_sigma_dac u_dac (
      .clk_i  (clk),
      .rst_i  (rst),
      .data_i (selected_wave),
      .dac_o  (dac_out)
   );

endmodule

// File: tb/tb_osc_wave_dac_core.sv
// Directed bench for osc_wave_dac_core: hand-computed spot values plus
// statistics windows over the selected waveform and DAC stream.
module tb_osc_wave_dac_core;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic [23:0] frequency = '0;
   logic [7:0]  duty_cycle = '0;
   logic [2:0]  wave_select = '0;
   logic [23:0] phase_out;
   logic [7:0]  square_out, sawtooth_out, triangle_out, sine_out, noise_out, selected_wave;
   logic        dac_out;

   osc_wave_dac_core dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .frequency     (frequency),
      .duty_cycle    (duty_cycle),
      .wave_select   (wave_select),
      .phase_out     (phase_out),
      .square_out    (square_out),
      .sawtooth_out  (sawtooth_out),
      .triangle_out  (triangle_out),
      .sine_out      (sine_out),
      .noise_out     (noise_out),
      .selected_wave (selected_wave),
      .dac_out       (dac_out)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference LFSR: Galois form, taps 0xB400, seed 0xACE1.
   logic [15:0] lfsr_m;
   always @(posedge clk or posedge rst) begin
      if (rst)         lfsr_m <= 16'hACE1;
      else if (enable) lfsr_m <= (lfsr_m >> 1) ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      enable = 1'b0;
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
   endtask

   int s_min, s_max, s_sum, s_dac, s_sq, s_nmis;
   task automatic run_stats(input int n);
      s_min = 255; s_max = 0; s_sum = 0; s_dac = 0; s_sq = 0; s_nmis = 0;
      for (int i = 0; i < n; i++) begin
         tick(1);
         if (int'(selected_wave) < s_min) s_min = int'(selected_wave);
         if (int'(selected_wave) > s_max) s_max = int'(selected_wave);
         s_sum += int'(selected_wave);
         s_dac += int'(dac_out);
         if (square_out == 8'hFF) s_sq++;
         if (noise_out !== lfsr_m[7:0]) s_nmis++;
      end
   endtask

   function automatic logic dac_close();
      int d;
      d = s_dac * 256 - s_sum;
      return (d <= 1024) && (d >= -1024);
   endfunction

   task automatic count_wraps(input logic [23:0] f, output int w);
      logic [23:0] prev;
      do_reset();
      frequency = f;
      enable = 1'b1;
      prev = '0;
      w = 0;
      for (int i = 0; i < 2000; i++) begin
         tick(1);
         if (phase_out < prev) w++;
         prev = phase_out;
      end
   endtask

   int w;

   initial begin
      // Reset values
      duty_cycle = 8'h80;
      tick(2);
      chk("rst_phase", phase_out, 24'h0);
      chk("rst_saw", sawtooth_out, 8'h00);
      chk("rst_tri", triangle_out, 8'h00);
      chk("rst_sine", sine_out, 8'd128);
      chk("rst_noise", noise_out, 8'hE1);
      chk("rst_dac", dac_out, 1'b0);
      chk("rst_square_duty80", square_out, 8'hFF);
      duty_cycle = 8'h00;
      #1;
      chk("rst_square_duty0", square_out, 8'h00);
      chk("rst_sel_square", selected_wave, 8'h00);

      // First steps at 0x080000 and freeze
      rst = 1'b0;
      duty_cycle = 8'h80;
      frequency = 24'h080000;
      enable = 1'b1;
      tick(1);
      chk("step1_phase", phase_out, 24'h080000);
      chk("step1_saw_latency", sawtooth_out, 8'h00);
      chk("step1_noise", noise_out, 8'h70);
      tick(1);
      chk("step2_phase", phase_out, 24'h100000);
      chk("step2_saw", sawtooth_out, 8'h08);
      chk("step2_tri", triangle_out, 8'h10);
      chk("step2_noise", noise_out, 8'h38);
      tick(1);
      chk("step3_noise", noise_out, 8'h9C);
      enable = 1'b0;
      tick(5);
      chk("frz_phase", phase_out, 24'h180000);
      chk("frz_saw", sawtooth_out, 8'h18);
      chk("frz_tri", triangle_out, 8'h30);
      chk("frz_noise", noise_out, 8'h9C);

      // Sine spot checks at quarter-cycle steps
      do_reset();
      frequency = 24'h400000;
      wave_select = 3'd3;
      enable = 1'b1;
      tick(1);
      chk("sine_q0", sine_out, 8'd128);
      tick(1);
      chk("sine_q1", sine_out, 8'd255);
      tick(1);
      chk("sine_q2", sine_out, 8'd128);
      tick(1);
      chk("sine_q3", sine_out, 8'd1);
      chk("sine_q3_sel", selected_wave, 8'd1);
      chk("tri_q3", triangle_out, 8'h7F);
      chk("saw_q3", sawtooth_out, 8'hC0);

      // DAC extremes on a frozen square
      do_reset();
      wave_select = 3'd0;
      duty_cycle = 8'h80;
      run_stats(256);
      chk("dac_255_ones", s_dac, 255);
      do_reset();
      duty_cycle = 8'h00;
      run_stats(64);
      chk("dac_0_ones", s_dac, 0);

      // Square 50% and 25%, undefined select code behaves as square
      do_reset();
      duty_cycle = 8'h80;
      frequency = 24'h080000;
      enable = 1'b1;
      run_stats(4096);
      chk("sq50_high", s_sq, 2048);
      chk("sq50_min", s_min, 0);
      chk("sq50_max", s_max, 255);
      chk("sq50_dac", dac_close(), 1'b1);
      duty_cycle = 8'h40;
      wave_select = 3'd6;
      run_stats(4096);
      chk("sq25_high", s_sq, 1024);
      chk("sq25_sel_sum", s_sum, 1024 * 255);
      chk("sq25_dac", dac_close(), 1'b1);

      // Saw, triangle, sine windows
      wave_select = 3'd1;
      run_stats(4096);
      chk("saw_min", s_min, 0);
      chk("saw_max", s_max, 248);
      chk("saw_avg", (s_sum / 4096 >= 100) && (s_sum / 4096 <= 155), 1'b1);
      chk("saw_dac", dac_close(), 1'b1);
      wave_select = 3'd2;
      run_stats(4096);
      chk("tri_min", s_min, 0);
      chk("tri_max", s_max, 255);
      chk("tri_avg", (s_sum / 4096 >= 100) && (s_sum / 4096 <= 155), 1'b1);
      chk("tri_dac", dac_close(), 1'b1);
      wave_select = 3'd3;
      run_stats(4096);
      chk("sine_min", s_min < 30, 1'b1);
      chk("sine_max", s_max > 225, 1'b1);
      chk("sine_avg", (s_sum / 4096 >= 100) && (s_sum / 4096 <= 155), 1'b1);
      chk("sine_dac", dac_close(), 1'b1);

      // Noise: sequence against reference, spread and mean
      do_reset();
      wave_select = 3'd4;
      enable = 1'b1;
      run_stats(4096);
      chk("noise_seq_mismatches", s_nmis, 0);
      chk("noise_spread", (s_max - s_min) > 200, 1'b1);
      chk("noise_avg", (s_sum / 4096 >= 100) && (s_sum / 4096 <= 155), 1'b1);
      chk("noise_dac", dac_close(), 1'b1);
      enable = 1'b0;
      run_stats(16);
      chk("noise_frozen_mismatches", s_nmis, 0);
      chk("noise_frozen_spread", s_max - s_min, 0);

      // Asynchronous reset between clock edges
      enable = 1'b1;
      tick(3);
      rst = 1'b1;
      #2;
      chk("async_rst_phase", phase_out, 24'h0);
      chk("async_rst_noise", noise_out, 8'hE1);
      chk("async_rst_saw", sawtooth_out, 8'h00);
      chk("async_rst_sine", sine_out, 8'd128);
      rst = 1'b0;

      // Phase wrap counts over 2000 clocks
      count_wraps(24'h010000, w);
      chk("wraps_010000", w, 7);
      count_wraps(24'h100000, w);
      chk("wraps_100000", w, 125);
      count_wraps(24'h400000, w);
      chk("wraps_400000", w, 500);
      count_wraps(24'h000000, w);
      chk("wraps_zero", w, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
